vga_timing_gen: RTL

- Generates the raster scan that drives the pixel pipeline: pixel coordinates DrawX/DrawY go to the color mapper, and HS/VS/BLANK/pixel-clock go to the VGA DAC.
- The color mapper consumes DrawX/DrawY and produces RGB some cycles later, so this block delays the sync and blank outputs by a programmable number of pixel clocks to keep them aligned with that RGB.
- Also emits frame and line strobes for per-frame logic (camera, sprite updates).

---
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ==== vga_timing_gen : raster counters, sync/blank decode with pipeline-matched delay, line/frame strobes ==== rev 1.0
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIPE_DLY  = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       VGA_CLK,
  output logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       frame_start,
  output logic       line_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  C_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  C_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] C_H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] C_V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] C_HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] C_HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] C_VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] C_VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
      $error("vga_timing_gen: PIPE_DLY must be within 0..7");
    end
  endgenerate

  logic       phase;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       h_wrap;
  logic       v_wrap;
  logic       hs_raw;
  logic       vs_raw;
  logic       blank_raw_n;

  assign h_wrap = (hc == C_H_LAST);
  assign v_wrap = (vc == C_V_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) phase <= 1'b0;
    else       phase <= ~phase;
  end

  assign pix_en  = phase;
  assign VGA_CLK = phase;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        hc <= '0;
        vc <= v_wrap ? '0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // Strobes mark the Clk cycle right after the wrapping pixel edge; pix_en keeps them 1 Clk wide.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_en & h_wrap;
      frame_start <= pix_en & h_wrap & v_wrap;
    end
  end

  assign DrawX      = hc;
  assign DrawY      = vc;
  assign VGA_SYNC_N = 1'b0;

  assign hs_raw      = ~(({1'b0, hc} >= C_HS_BEG) && ({1'b0, hc} < C_HS_END));
  assign vs_raw      = ~(({1'b0, vc} >= C_VS_BEG) && ({1'b0, vc} < C_VS_END));
  assign blank_raw_n = ({1'b0, hc} < C_H_VIS) && ({1'b0, vc} < C_V_VIS);

  generate
    if (PIPE_DLY == 0) begin : g_no_delay
      // (0,0) decodes as visible, so reset must force blanking while it is held.
      assign VGA_HS      = hs_raw;
      assign VGA_VS      = vs_raw;
      assign VGA_BLANK_N = blank_raw_n & ~Reset;
    end else begin : g_delay
      logic [PIPE_DLY-1:0] hs_d;
      logic [PIPE_DLY-1:0] vs_d;
      logic [PIPE_DLY-1:0] blank_d;

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          hs_d    <= '1;
          vs_d    <= '1;
          blank_d <= '0;
        end else if (pix_en) begin
          hs_d[0]    <= hs_raw;
          vs_d[0]    <= vs_raw;
          blank_d[0] <= blank_raw_n;
          for (int i = 1; i < PIPE_DLY; i++) begin
            hs_d[i]    <= hs_d[i-1];
            vs_d[i]    <= vs_d[i-1];
            blank_d[i] <= blank_d[i-1];
          end
        end
      end

      assign VGA_HS      = hs_d[PIPE_DLY-1];
      assign VGA_VS      = vs_d[PIPE_DLY-1];
      assign VGA_BLANK_N = blank_d[PIPE_DLY-1];
    end
  endgenerate

endmodule
`default_nettype wire
